// File: rtl/io_port_hub.sv
// CPU-facing I/O hub: 7-segment output, switch input with debounced Confirm handshake,
// and keyboard byte FIFO, all completing through a one-cycle Ack strobe.
module io_port_hub #(
    parameter int DATA_W   = 32,
    parameter int SW_W     = 18,
    parameter int DIGITS   = 8,
    parameter int KB_DEPTH = 8,
    parameter int DEB_CYC  = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Enable,
    input  logic [1:0]          IO,
    input  logic [DATA_W-1:0]   Data_Out_Value,
    output logic [DATA_W-1:0]   Data_In,
    input  logic [SW_W-1:0]     Raw_Input,
    input  logic                Confirm,
    input  logic [7:0]          Kb_Byte,
    input  logic                Kb_Valid,
    output logic                Interrupt,
    output logic                Ack,
    output logic                Kb_Empty,
    output logic                Kb_Overflow,
    output logic [7*DIGITS-1:0] Display
);

    localparam int PTR_W = $clog2(KB_DEPTH);
    localparam int CNT_W = $clog2(KB_DEPTH + 1);
    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    typedef enum logic [2:0] {IDLE, SW_PRESS, SW_RELEASE, KB_WAIT, DONE} state_t;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    state_t                         state_q, state_d;
    logic [1:0]                     sync_q, sync_d;
    logic                           level_q, level_d;
    logic [DEB_W-1:0]               deb_cnt_q, deb_cnt_d;
    logic                           deb_flip;
    logic [DATA_W-1:0]              data_in_q, data_in_d;
    logic [DIGITS-1:0][6:0]         disp_q, disp_d;
    logic                           ack_q, ack_d;
    logic [KB_DEPTH-1:0][7:0]       mem_q, mem_d;
    logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic                           empty_q, empty_d;
    logic                           ovf_q, ovf_d;
    logic                           pop, push, full;

    // deb_flip marks the cycle in which the debounced level is about to change,
    // so the FSM reacts on the same edge that the level updates.
    always_comb begin
        sync_d    = {sync_q[0], Confirm};
        level_d   = level_q;
        deb_cnt_d = deb_cnt_q;
        deb_flip  = 1'b0;
        if (sync_q[1] == level_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_W'(DEB_CYC - 1)) begin
            deb_flip  = 1'b1;
            level_d   = sync_q[1];
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        data_in_d = data_in_q;
        disp_d    = disp_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (Enable) begin
                    case (IO)
                        2'd0: begin
                            for (int i = 0; i < DIGITS; i++) begin
                                disp_d[i] = hex7(Data_Out_Value[4*i +: 4]);
                            end
                            state_d = DONE;
                        end
                        2'd1: state_d = SW_PRESS;
                        2'd2: begin
                            if (count_q != '0) begin
                                pop       = 1'b1;
                                data_in_d = DATA_W'(mem_q[rd_ptr_q]);
                                state_d   = DONE;
                            end else begin
                                state_d = KB_WAIT;
                            end
                        end
                        default: state_d = DONE;
                    endcase
                end
            end
            SW_PRESS: begin
                if (!Enable) begin
                    state_d = IDLE;
                end else if (deb_flip && sync_q[1]) begin
                    data_in_d = DATA_W'($signed(Raw_Input));
                    state_d   = SW_RELEASE;
                end
            end
            SW_RELEASE: begin
                if (!Enable) begin
                    state_d = IDLE;
                end else if (deb_flip && !sync_q[1]) begin
                    state_d = DONE;
                end
            end
            KB_WAIT: begin
                if (!Enable) begin
                    state_d = IDLE;
                end else if (count_q != '0) begin
                    pop       = 1'b1;
                    data_in_d = DATA_W'(mem_q[rd_ptr_q]);
                    state_d   = DONE;
                end
            end
            default: begin
                if (!Enable) begin
                    state_d = IDLE;
                end
            end
        endcase
        ack_d = (state_d == DONE) && (state_q != DONE);
    end

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    always_comb begin
        full     = (count_q == CNT_W'(KB_DEPTH));
        push     = Kb_Valid && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            mem_d[wr_ptr_q] = Kb_Byte;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        if (Kb_Valid && full && !pop) begin
            ovf_d = 1'b1;
        end
        empty_d = (count_d == '0);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
            data_in_q <= '0;
            disp_q    <= {DIGITS{7'b1000000}};
            ack_q     <= 1'b0;
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
            data_in_q <= data_in_d;
            disp_q    <= disp_d;
            ack_q     <= ack_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
        end
    end

    assign Interrupt   = (state_q == SW_PRESS) || (state_q == SW_RELEASE) || (state_q == KB_WAIT);
    assign Ack         = ack_q;
    assign Data_In     = data_in_q;
    assign Display     = disp_q;
    assign Kb_Empty    = empty_q;
    assign Kb_Overflow = ovf_q;

endmodule

// File: tb/tb_io_port_hub.sv
// Directed self-checking bench for io_port_hub: display write, switch handshake with
// bouncing Confirm, keyboard FIFO ordering/overflow, KB_WAIT abort and asynchronous reset.
module tb_io_port_hub;

    logic        Clock;
    logic        Reset;
    logic        Enable;
    logic [1:0]  IO;
    logic [31:0] Data_Out_Value;
    logic [31:0] Data_In;
    logic [17:0] Raw_Input;
    logic        Confirm;
    logic [7:0]  Kb_Byte;
    logic        Kb_Valid;
    logic        Interrupt;
    logic        Ack;
    logic        Kb_Empty;
    logic        Kb_Overflow;
    logic [55:0] Display;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [55:0] DISP_RESET = {8{7'b1000000}};
    localparam logic [55:0] DISP_1234ABCD = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                             7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};

    io_port_hub #(
        .DATA_W(32), .SW_W(18), .DIGITS(8), .KB_DEPTH(8), .DEB_CYC(4)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .IO(IO),
        .Data_Out_Value(Data_Out_Value), .Data_In(Data_In), .Raw_Input(Raw_Input),
        .Confirm(Confirm), .Kb_Byte(Kb_Byte), .Kb_Valid(Kb_Valid),
        .Interrupt(Interrupt), .Ack(Ack), .Kb_Empty(Kb_Empty),
        .Kb_Overflow(Kb_Overflow), .Display(Display)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic stepClock();
        @(posedge Clock);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] io,
                                 input logic kb_v, input logic [7:0] kb_b);
        Enable   = en;
        IO       = io;
        Kb_Valid = kb_v;
        Kb_Byte  = kb_b;
        stepClock();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        Reset = 1'b1; Enable = 1'b0; IO = 2'd0; Data_Out_Value = '0;
        Raw_Input = '0; Confirm = 1'b0; Kb_Byte = '0; Kb_Valid = 1'b0;
        stepClock();
        stepClock();
        checkOutput("reset_data_in", 64'(Data_In), 64'h0);
        checkOutput("reset_display", 64'(Display), 64'(DISP_RESET));
        checkOutput("reset_interrupt", 64'(Interrupt), 64'h0);
        checkOutput("reset_ack", 64'(Ack), 64'h0);
        checkOutput("reset_kb_empty", 64'(Kb_Empty), 64'h1);
        checkOutput("reset_kb_overflow", 64'(Kb_Overflow), 64'h0);
        Reset = 1'b0;
        stepClock();

        $display("[TB] 7-segment write");
        Data_Out_Value = 32'h1234ABCD;
        applyStimulus(1'b1, 2'd0, 1'b0, 8'h00);
        checkOutput("seg_display", 64'(Display), 64'(DISP_1234ABCD));
        checkOutput("seg_ack_high", 64'(Ack), 64'h1);
        applyStimulus(1'b1, 2'd0, 1'b0, 8'h00);
        checkOutput("seg_ack_one_cycle", 64'(Ack), 64'h0);
        Data_Out_Value = 32'h00000000;
        applyStimulus(1'b1, 2'd0, 1'b0, 8'h00);
        checkOutput("seg_no_retrigger_ack", 64'(Ack), 64'h0);
        checkOutput("seg_no_retrigger_disp", 64'(Display), 64'(DISP_1234ABCD));
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00);
        stepClock();

        $display("[TB] switch read with bouncing Confirm");
        Raw_Input = 18'h3FFFF;
        applyStimulus(1'b1, 2'd1, 1'b0, 8'h00);
        checkOutput("sw_interrupt", 64'(Interrupt), 64'h1);
        for (int k = 0; k < 3; k++) begin
            Confirm = 1'b1;
            stepClock();
            Confirm = 1'b0;
            stepClock();
        end
        Confirm = 1'b1;
        repeat (5) stepClock();
        checkOutput("sw_data_not_yet", 64'(Data_In), 64'h0);
        stepClock();
        checkOutput("sw_data_loaded", 64'(Data_In), 64'hFFFFFFFF);
        checkOutput("sw_interrupt_held", 64'(Interrupt), 64'h1);
        Confirm = 1'b0;
        Raw_Input = 18'h00005;
        repeat (5) stepClock();
        checkOutput("sw_ack_before_release", 64'(Ack), 64'h0);
        checkOutput("sw_interrupt_before_release", 64'(Interrupt), 64'h1);
        stepClock();
        checkOutput("sw_ack_release", 64'(Ack), 64'h1);
        checkOutput("sw_interrupt_done", 64'(Interrupt), 64'h0);
        checkOutput("sw_data_kept", 64'(Data_In), 64'hFFFFFFFF);
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00);
        checkOutput("sw_display_held", 64'(Display), 64'(DISP_1234ABCD));

        $display("[TB] keyboard FIFO reads");
        applyStimulus(1'b0, 2'd0, 1'b1, 8'h1C);
        checkOutput("kb_not_empty", 64'(Kb_Empty), 64'h0);
        applyStimulus(1'b0, 2'd0, 1'b1, 8'h32);
        applyStimulus(1'b1, 2'd2, 1'b0, 8'h00);
        checkOutput("kb_read1", 64'(Data_In), 64'h0000001C);
        checkOutput("kb_read1_ack", 64'(Ack), 64'h1);
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00);
        applyStimulus(1'b1, 2'd2, 1'b0, 8'h00);
        checkOutput("kb_read2", 64'(Data_In), 64'h00000032);
        checkOutput("kb_empty_after", 64'(Kb_Empty), 64'h1);
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00);

        $display("[TB] keyboard FIFO overflow and drain");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 2'd0, 1'b1, 8'(8'h10 + i));
        end
        checkOutput("kb_full_no_ovf", 64'(Kb_Overflow), 64'h0);
        applyStimulus(1'b0, 2'd0, 1'b1, 8'h18);
        checkOutput("kb_ovf_set", 64'(Kb_Overflow), 64'h1);
        Kb_Valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'd2, 1'b0, 8'h00);
            checkOutput($sformatf("kb_drain%0d", i), 64'(Data_In), 64'(32'h10 + i));
            applyStimulus(1'b0, 2'd0, 1'b0, 8'h00);
        end
        checkOutput("kb_drain_empty", 64'(Kb_Empty), 64'h1);
        checkOutput("kb_ovf_sticky", 64'(Kb_Overflow), 64'h1);

        $display("[TB] keyboard wait abort and completion");
        applyStimulus(1'b1, 2'd2, 1'b0, 8'h00);
        checkOutput("kbw_interrupt", 64'(Interrupt), 64'h1);
        repeat (4) stepClock();
        applyStimulus(1'b0, 2'd2, 1'b0, 8'h00);
        checkOutput("kbw_abort_interrupt", 64'(Interrupt), 64'h0);
        checkOutput("kbw_abort_ack", 64'(Ack), 64'h0);
        checkOutput("kbw_abort_data", 64'(Data_In), 64'h00000017);
        applyStimulus(1'b1, 2'd2, 1'b0, 8'h00);
        applyStimulus(1'b1, 2'd1, 1'b0, 8'h00);
        applyStimulus(1'b1, 2'd1, 1'b1, 8'h5A);
        checkOutput("kbw_push_ack_low", 64'(Ack), 64'h0);
        checkOutput("kbw_push_interrupt", 64'(Interrupt), 64'h1);
        checkOutput("kbw_push_not_empty", 64'(Kb_Empty), 64'h0);
        applyStimulus(1'b1, 2'd1, 1'b0, 8'h00);
        checkOutput("kbw_ack", 64'(Ack), 64'h1);
        checkOutput("kbw_data", 64'(Data_In), 64'h0000005A);
        checkOutput("kbw_interrupt_done", 64'(Interrupt), 64'h0);
        checkOutput("kbw_empty_after", 64'(Kb_Empty), 64'h1);
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00);

        $display("[TB] reserved IO code");
        applyStimulus(1'b1, 2'd3, 1'b0, 8'h00);
        checkOutput("io3_ack", 64'(Ack), 64'h1);
        checkOutput("io3_data", 64'(Data_In), 64'h0000005A);
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00);

        $display("[TB] asynchronous reset during switch wait");
        applyStimulus(1'b1, 2'd1, 1'b0, 8'h00);
        checkOutput("rst_pre_interrupt", 64'(Interrupt), 64'h1);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("rst_async_interrupt", 64'(Interrupt), 64'h0);
        checkOutput("rst_async_display", 64'(Display), 64'(DISP_RESET));
        checkOutput("rst_async_data", 64'(Data_In), 64'h0);
        checkOutput("rst_async_ovf", 64'(Kb_Overflow), 64'h0);
        checkOutput("rst_async_empty", 64'(Kb_Empty), 64'h1);
        Enable = 1'b0;
        stepClock();
        Reset = 1'b0;
        stepClock();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_port_hub.md
Name: io_port_hub

Overview:
Parametrised CPU-facing I/O hub, successor to the fixed 8-digit switch/keyboard/7-segment port. Single clock domain, generic digit count and data/switch widths. Adds a debounced Confirm handshake FSM, a keyboard byte FIFO with overflow flag, and an explicit one-cycle Ack completion strobe for the pipeline stall logic. VGA drawing is outside this block; IO code 3 is reserved.

Parameters:
DATA_W, 32, CPU data width; DIGITS*4 <= DATA_W required
SW_W, 18, switch input width; SW_W <= DATA_W
DIGITS, 8, number of 7-segment digits driven
KB_DEPTH, 8, keyboard FIFO depth, power of two >= 2
DEB_CYC, 4, debounce stable-cycle count for Confirm, >= 1

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  reset
Enable  in  1  CPU I/O request, held high until Ack
IO  in  2  0=7seg out, 1=switch in, 2=keyboard in, 3=reserved
Data_Out_Value  in  DATA_W  value to display
Data_In  out  DATA_W  value returned to CPU
Raw_Input  in  SW_W  switches, signed
Confirm  in  1  raw push-button, asynchronous
Kb_Byte  in  8  keyboard scan byte
Kb_Valid  in  1  one-cycle push strobe for Kb_Byte
Interrupt  out  1  high while waiting for user input
Ack  out  1  one-cycle operation-complete strobe
Kb_Empty  out  1  FIFO empty
Kb_Overflow  out  1  sticky: byte dropped on full FIFO
Display  out  7*DIGITS  digit i at [7i+6:7i], active-low gfedcba

Behaviour:
- Reset: asynchronous, active-high. Data_In=0, Display all 7'b1000000, Interrupt=0, Ack=0, Kb_Empty=1, Kb_Overflow=0, FIFO pointers/count=0, debouncer level=0, FSM=IDLE.
- Confirm: 2-FF synchroniser, then debouncer. Level updates only after DEB_CYC consecutive equal synced samples. Press-to-level latency is 2+DEB_CYC cycles.
- FSM states: IDLE, SW_PRESS, SW_RELEASE, KB_WAIT, DONE.
- IDLE, Enable=1:
  - IO=0: Display digit i <= hex(Data_Out_Value[4i+3:4i]); go DONE.
  - IO=1: go SW_PRESS.
  - IO=2: if FIFO non-empty, pop, Data_In <= zero-extended byte, go DONE; else go KB_WAIT.
  - IO=3: go DONE, no side effect.
- SW_PRESS: Interrupt=1. On debounced rise, Data_In <= sign-extended Raw_Input sampled that cycle; go SW_RELEASE.
- SW_RELEASE: Interrupt=1. On debounced fall, go DONE.
- KB_WAIT: Interrupt=1. When FIFO becomes non-empty, pop next edge, load Data_In, go DONE.
- DONE: Ack=1 for exactly the cycle entering DONE; Interrupt=0. Stay until Enable=0, then IDLE. This prevents re-triggering on a held Enable.
- Abort: Enable=0 in SW_PRESS, SW_RELEASE or KB_WAIT -> IDLE next edge. Interrupt=0, no Ack, Data_In and FIFO unchanged.
- IO changes while busy are ignored; the operation latched in IDLE completes.
- Hex table, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Display is registered and holds its value between writes.
- FIFO pushes on Kb_Valid regardless of Enable/IO.
  - Push and pop in the same cycle while non-empty: both occur, count unchanged.
  - Push while empty with pop requested: no bypass; the pop happens the next cycle.
  - Push while full without pop: byte dropped, Kb_Overflow=1 until Reset. Push while full with pop: accepted.
  - Pointers wrap modulo KB_DEPTH.
  - Kb_Empty is registered from count.

Test Plan:
- Reset mid-SW_PRESS (Interrupt=1) -> Interrupt=0, Display all 1000000, Data_In=0 immediately, without a clock edge.
- IO=0, Enable=1, Data_Out_Value=0x1234ABCD -> next edge Display digit7..0 = 1,2,3,4,A,b,C,d codes; Ack one cycle; no second Ack while Enable stays high.
- IO=1, Raw_Input=18'h3FFFF, Confirm pressed with 3 cycles of bounce then stable -> Interrupt high; Data_In=0xFFFFFFFF only after 2+DEB_CYC stable cycles; Ack one cycle after release is debounced.
- Push 0x1C,0x32 via Kb_Valid; two IO=2 reads -> Data_In=0x0000001C then 0x00000032; Kb_Empty=1 after the second read.
- Push KB_DEPTH+1 bytes with no reads -> Kb_Overflow=1, the last byte is lost; drain returns the first KB_DEPTH bytes in order.
- IO=2 with FIFO empty, drop Enable after 5 cycles -> IDLE, no Ack, Interrupt=0. Repeat without abort, push 0x5A -> Ack 2 cycles later, Data_In=0x5A.
